// File: rtl/spi_pkg.sv
// Shared definitions for the SPI master: FSM state encoding, SPI mode constants
// ({CPOL,CPHA}) and small helpers used when elaborating mode-dependent behaviour.
package spi_pkg;

  // Transfer FSM states
  typedef enum logic [2:0] {
    ST_IDL   = 3'd0,
    ST_LEAD  = 3'd1,
    ST_XFER  = 3'd2,
    ST_TRAIL = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  // SPI modes encoded as {CPOL,CPHA}
  localparam logic [1:0] SPI_MODE0 = 2'b00;
  localparam logic [1:0] SPI_MODE1 = 2'b01;
  localparam logic [1:0] SPI_MODE2 = 2'b10;
  localparam logic [1:0] SPI_MODE3 = 2'b11;

  // Pack polarity/phase into a mode number
  function automatic logic [1:0] spi_mode(input logic cpol, input logic cpha);
    return {cpol, cpha};
  endfunction

  // Modes 1 and 3 launch data on the leading SCLK edge and sample on the trailing one
  function automatic logic shift_on_lead(input logic [1:0] mode);
    case (mode)
      SPI_MODE0, SPI_MODE2: return 1'b0;
      SPI_MODE1, SPI_MODE3: return 1'b1;
      default:              return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/spi_clkgen.sv
// SCLK half-period timer: emits a one-cycle tick every DIV enabled cycles.
// Ports:
//   clk_i    system clock
//   rst_i    synchronous active-high reset
//   en_i     high while the master is in LEAD/XFER/TRAIL; low clears the count
//   tick_c_o combinational tick, high in the last cycle of each half period
module spi_clkgen #(
  parameter int unsigned DIV = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic en_i,
  output logic tick_c_o
);

  localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] cnt_q;

  assign tick_c_o = en_i && (cnt_q == CW'(DIV - 1));

  // Count restarts on every tick so each phase lasts exactly DIV cycles
  always_ff @(posedge clk_i) begin
    if (rst_i || !en_i) begin
      cnt_q <= '0;
    end else if (tick_c_o) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

endmodule

// File: rtl/spi_master.sv
// SPI master: one DW-bit word per req/rdy handshake with programmable SCLK
// divider, CPOL/CPHA mode, bit order and active-low chip select.
// Optional receive path enabled by defining SPI_RX_EN; otherwise sdi is ignored
// and rx_dat/rx_vld are tied low.
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   req/rdy/dat   word handshake; dat sampled on the accept cycle (req && rdy)
//   sclk/sdo/sdi  serial clock, data out, data in
//   cs_n          chip select, active low
//   rx_dat/rx_vld received word and its one-cycle valid pulse
//   snt           one-cycle pulse after the word is sent and cs_n is high
module spi_master
  import spi_pkg::*;
#(
  parameter int unsigned DW   = 8,
  parameter int unsigned DIV  = 2,
  parameter bit          CPOL = 1'b0,
  parameter bit          CPHA = 1'b0,
  parameter bit          LSBF = 1'b0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req,
  output logic          rdy,
  input  logic [DW-1:0] dat,
  output logic          sclk,
  output logic          sdo,
  input  logic          sdi,
  output logic          cs_n,
  output logic [DW-1:0] rx_dat,
  output logic          rx_vld,
  output logic          snt
);

  localparam int unsigned EW            = $clog2(2 * DW);
  localparam bit          SHIFT_ON_LEAD = shift_on_lead(spi_mode(CPOL, CPHA));

  state_e        state_q;
  logic          rdy_q;
  logic          cs_n_q;
  logic          sclk_q;
  logic          sdo_q;
  logic          snt_q;
  logic [DW-1:0] tx_q;
  logic [EW-1:0] ecnt_q;

  logic tick_c;
  logic clk_en_c;
  logic lead_edge_c;
  logic last_edge_c;

  // Bit that goes out next, honouring bit order
  function automatic logic first_bit(input logic [DW-1:0] w);
    return LSBF ? w[0] : w[DW-1];
  endfunction

  // Drop the bit just sent; zero fill, no wrap
  function automatic logic [DW-1:0] shift_word(input logic [DW-1:0] w);
    return LSBF ? {1'b0, w[DW-1:1]} : {w[DW-2:0], 1'b0};
  endfunction

  assign clk_en_c    = state_q inside {ST_LEAD, ST_XFER, ST_TRAIL};
  assign lead_edge_c = ~ecnt_q[0];
  assign last_edge_c = (ecnt_q == EW'(2 * DW - 1));

  spi_clkgen #(
    .DIV (DIV)
  ) u_clkgen (
    .clk_i    (clk),
    .rst_i    (rst),
    .en_i     (clk_en_c),
    .tick_c_o (tick_c)
  );

  // Transfer FSM with registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDL;
      rdy_q   <= 1'b1;
      cs_n_q  <= 1'b1;
      sclk_q  <= CPOL;
      sdo_q   <= 1'b0;
      snt_q   <= 1'b0;
      tx_q    <= '0;
      ecnt_q  <= '0;
    end else begin
      snt_q <= 1'b0;
      case (state_q)
        ST_IDL: begin
          if (req) begin
            state_q <= ST_LEAD;
            rdy_q   <= 1'b0;
            cs_n_q  <= 1'b0;
            sclk_q  <= CPOL;
            ecnt_q  <= '0;
            // CPHA=0 presents the first bit before the first SCLK edge
            if (SHIFT_ON_LEAD) begin
              tx_q <= dat;
            end else begin
              sdo_q <= first_bit(dat);
              tx_q  <= shift_word(dat);
            end
          end
        end
        ST_LEAD: begin
          if (tick_c) begin
            state_q <= ST_XFER;
          end
        end
        ST_XFER: begin
          if (tick_c) begin
            sclk_q <= ~sclk_q;
            ecnt_q <= ecnt_q + EW'(1);
            // Launch edge; the final trailing edge never launches
            if ((lead_edge_c == SHIFT_ON_LEAD) && !last_edge_c) begin
              sdo_q <= first_bit(tx_q);
              tx_q  <= shift_word(tx_q);
            end
            if (last_edge_c) begin
              state_q <= ST_TRAIL;
            end
          end
        end
        ST_TRAIL: begin
          if (tick_c) begin
            state_q <= ST_DONE;
            cs_n_q  <= 1'b1;
            snt_q   <= 1'b1;
          end
        end
        ST_DONE: begin
          state_q <= ST_IDL;
          rdy_q   <= 1'b1;
        end
        default: begin
          state_q <= ST_IDL;
          rdy_q   <= 1'b1;
          cs_n_q  <= 1'b1;
          sclk_q  <= CPOL;
        end
      endcase
    end
  end

  assign rdy  = rdy_q;
  assign cs_n = cs_n_q;
  assign sclk = sclk_q;
  assign sdo  = sdo_q;
  assign snt  = snt_q;

`ifdef SPI_RX_EN
  logic [DW-1:0] rx_q;
  logic [DW-1:0] rx_dat_q;
  logic          rx_vld_q;

  // Receive shifter samples on the edge opposite to launch; result published with snt
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_q     <= '0;
      rx_dat_q <= '0;
      rx_vld_q <= 1'b0;
    end else begin
      rx_vld_q <= 1'b0;
      if ((state_q == ST_XFER) && tick_c && (lead_edge_c != SHIFT_ON_LEAD)) begin
        rx_q <= LSBF ? {sdi, rx_q[DW-1:1]} : {rx_q[DW-2:0], sdi};
      end
      if ((state_q == ST_TRAIL) && tick_c) begin
        rx_dat_q <= rx_q;
        rx_vld_q <= 1'b1;
      end
    end
  end

  assign rx_dat = rx_dat_q;
  assign rx_vld = rx_vld_q;
`else
  logic unused_sdi;

  assign unused_sdi = sdi;
  assign rx_dat     = '0;
  assign rx_vld     = 1'b0;
`endif

endmodule

// File: tb/tb_spi_master.sv
// Directed bench for spi_master: four DW=8/DIV=2 instances (modes 0..3, modes
// 1..3 in loopback) plus one DW=12/DIV=1/LSB-first instance in loopback.
// Cycle numbers count the accept cycle (req && rdy) as cycle 0.
module tb_spi_master;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  logic       req_m    [4];
  logic [7:0] dat_m    [4];
  logic       rdy_m    [4];
  logic       sclk_m   [4];
  logic       sdo_m    [4];
  logic       cs_n_m   [4];
  logic [7:0] rx_dat_m [4];
  logic       rx_vld_m [4];
  logic       snt_m    [4];
  logic       sdi_tog;

  for (genvar g = 0; g < 4; g++) begin : g_mode
    spi_master #(
      .DW   (8),
      .DIV  (2),
      .CPOL (g >= 2),
      .CPHA (g % 2 == 1),
      .LSBF (1'b0)
    ) u_dut (
      .clk    (clk),
      .rst    (rst),
      .req    (req_m[g]),
      .rdy    (rdy_m[g]),
      .dat    (dat_m[g]),
      .sclk   (sclk_m[g]),
      .sdo    (sdo_m[g]),
      .sdi    ((g == 0) ? sdi_tog : sdo_m[g]),
      .cs_n   (cs_n_m[g]),
      .rx_dat (rx_dat_m[g]),
      .rx_vld (rx_vld_m[g]),
      .snt    (snt_m[g])
    );
  end

  logic        req12;
  logic [11:0] dat12;
  logic        rdy12, sclk12, sdo12, cs_n12, rx_vld12, snt12;
  logic [11:0] rx_dat12;

  spi_master #(
    .DW   (12),
    .DIV  (1),
    .CPOL (1'b0),
    .CPHA (1'b0),
    .LSBF (1'b1)
  ) u_dut12 (
    .clk    (clk),
    .rst    (rst),
    .req    (req12),
    .rdy    (rdy12),
    .dat    (dat12),
    .sclk   (sclk12),
    .sdo    (sdo12),
    .sdi    (sdo12),
    .cs_n   (cs_n12),
    .rx_dat (rx_dat12),
    .rx_vld (rx_vld12),
    .snt    (snt12)
  );

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int m = 0; m < 4; m++) begin
      logic pol;
      pol = (m >= 2);
      checks++; if (rdy_m[m] !== 1'b1) begin errors++; $display("FAIL reset_rdy m%0d got %b want 1", m, rdy_m[m]); end
      checks++; if (cs_n_m[m] !== 1'b1) begin errors++; $display("FAIL reset_cs_n m%0d got %b want 1", m, cs_n_m[m]); end
      checks++; if (sclk_m[m] !== pol) begin errors++; $display("FAIL reset_sclk m%0d got %b want %b", m, sclk_m[m], pol); end
      checks++; if (sdo_m[m] !== 1'b0) begin errors++; $display("FAIL reset_sdo m%0d got %b want 0", m, sdo_m[m]); end
      checks++; if (snt_m[m] !== 1'b0) begin errors++; $display("FAIL reset_snt m%0d got %b want 0", m, snt_m[m]); end
      checks++; if (rx_vld_m[m] !== 1'b0) begin errors++; $display("FAIL reset_rx_vld m%0d got %b want 0", m, rx_vld_m[m]); end
      checks++; if (rx_dat_m[m] !== 8'h00) begin errors++; $display("FAIL reset_rx_dat m%0d got %h want 00", m, rx_dat_m[m]); end
    end
    checks++; if ({rdy12, cs_n12, sclk12, sdo12, snt12, rx_vld12} !== 6'b110000) begin
      errors++; $display("FAIL reset_dw12_ctl got %b want 110000", {rdy12, cs_n12, sclk12, sdo12, snt12, rx_vld12});
    end
    checks++; if (rx_dat12 !== 12'h000) begin errors++; $display("FAIL reset_dw12_rx_dat got %h want 000", rx_dat12); end
    rst = 1'b0;
  endtask

  // Mode 0, A5, sdi toggling every cycle (low at every sampling edge, so rx_dat stays 00)
  task automatic test_mode0();
    logic [7:0] word = '0;
    int   nrise = 0, nsnt = 0, snt_cyc = 0, nvld = 0, vld_cyc = 0, cs_bad = 0, rx_bad = 0;
    logic prev, cs_at_snt = 1'b0, rdy_busy = 1'b1, rdy_after = 1'b0;
    @(negedge clk);
    dat_m[0] = 8'hA5; req_m[0] = 1'b1;
    checks++; if (rdy_m[0] !== 1'b1) begin errors++; $display("FAIL m0_rdy_idle got %b want 1", rdy_m[0]); end
    prev = sclk_m[0];
    @(posedge clk);
    for (int c = 1; c <= 50; c++) begin
      @(negedge clk);
      req_m[0] = 1'b0;
      dat_m[0] = 8'h00;
      sdi_tog  = ~sdi_tog;
      if (sclk_m[0] && !prev) begin
        word = {word[6:0], sdo_m[0]};
        nrise++;
        if (cs_n_m[0] !== 1'b0) cs_bad++;
      end
      prev = sclk_m[0];
      if (snt_m[0] === 1'b1) begin nsnt++; snt_cyc = c; cs_at_snt = cs_n_m[0]; end
      if (rx_vld_m[0] === 1'b1) begin nvld++; vld_cyc = c; end
      if (rx_dat_m[0] !== 8'h00) rx_bad++;
      if (c == 10) rdy_busy = rdy_m[0];
      if (c == 38) rdy_after = rdy_m[0];
    end
    checks++; if (word !== 8'hA5) begin errors++; $display("FAIL m0_sdo_bits got %h want a5", word); end
    checks++; if (nrise != 8) begin errors++; $display("FAIL m0_rising_edges got %0d want 8", nrise); end
    checks++; if (cs_bad != 0) begin errors++; $display("FAIL m0_cs_low_at_edges got %0d bad want 0", cs_bad); end
    checks++; if (nsnt != 1 || snt_cyc != 37) begin errors++; $display("FAIL m0_snt_latency got %0d pulses at cycle %0d want 1 at 37", nsnt, snt_cyc); end
    checks++; if (cs_at_snt !== 1'b1) begin errors++; $display("FAIL m0_cs_n_at_snt got %b want 1", cs_at_snt); end
    checks++; if (rdy_busy !== 1'b0) begin errors++; $display("FAIL m0_rdy_busy got %b want 0", rdy_busy); end
    checks++; if (rdy_after !== 1'b1) begin errors++; $display("FAIL m0_rdy_after_snt got %b want 1", rdy_after); end
    checks++; if (rx_bad != 0) begin errors++; $display("FAIL m0_rx_dat got %0d nonzero cycles want 0", rx_bad); end
`ifdef SPI_RX_EN
    checks++; if (nvld != 1 || vld_cyc != 37) begin errors++; $display("FAIL m0_rx_vld got %0d pulses at cycle %0d want 1 at 37", nvld, vld_cyc); end
`else
    checks++; if (nvld != 0) begin errors++; $display("FAIL m0_rx_vld got %0d pulses at cycle %0d want 0", nvld, vld_cyc); end
`endif
  endtask

  // Modes 1..3 in loopback, A5 on each
  task automatic test_modes();
    logic [7:0] word [4];
    int   nsamp [4], snt_cyc [4], vld_cyc [4], nvld [4];
    logic prev [4];
    @(negedge clk);
    for (int m = 1; m < 4; m++) begin
      logic pol;
      pol = (m >= 2);
      checks++; if (sclk_m[m] !== pol) begin errors++; $display("FAIL mode%0d_idle_sclk got %b want %b", m, sclk_m[m], pol); end
      dat_m[m] = 8'hA5; req_m[m] = 1'b1;
      word[m] = '0; nsamp[m] = 0; snt_cyc[m] = 0; vld_cyc[m] = 0; nvld[m] = 0; prev[m] = sclk_m[m];
    end
    @(posedge clk);
    for (int c = 1; c <= 50; c++) begin
      @(negedge clk);
      for (int m = 1; m < 4; m++) begin
        logic samp_lvl;
        samp_lvl = (m == 3);
        req_m[m] = 1'b0;
        if (sclk_m[m] !== prev[m] && sclk_m[m] === samp_lvl) begin
          word[m] = {word[m][6:0], sdo_m[m]};
          nsamp[m]++;
        end
        prev[m] = sclk_m[m];
        if (snt_m[m] === 1'b1) snt_cyc[m] = c;
        if (rx_vld_m[m] === 1'b1) begin nvld[m]++; vld_cyc[m] = c; end
      end
    end
    for (int m = 1; m < 4; m++) begin
      logic pol;
      pol = (m >= 2);
      checks++; if (word[m] !== 8'hA5 || nsamp[m] != 8) begin errors++; $display("FAIL mode%0d_sdo got %h in %0d samples want a5 in 8", m, word[m], nsamp[m]); end
      checks++; if (snt_cyc[m] != 37) begin errors++; $display("FAIL mode%0d_snt_cycle got %0d want 37", m, snt_cyc[m]); end
      checks++; if (sclk_m[m] !== pol) begin errors++; $display("FAIL mode%0d_end_sclk got %b want %b", m, sclk_m[m], pol); end
`ifdef SPI_RX_EN
      checks++; if (rx_dat_m[m] !== 8'hA5) begin errors++; $display("FAIL mode%0d_rx_dat got %h want a5", m, rx_dat_m[m]); end
      checks++; if (nvld[m] != 1 || vld_cyc[m] != 37) begin errors++; $display("FAIL mode%0d_rx_vld got %0d at %0d want 1 at 37", m, nvld[m], vld_cyc[m]); end
`else
      checks++; if (rx_dat_m[m] !== 8'h00) begin errors++; $display("FAIL mode%0d_rx_dat got %h want 00", m, rx_dat_m[m]); end
      checks++; if (nvld[m] != 0) begin errors++; $display("FAIL mode%0d_rx_vld got %0d pulses want 0", m, nvld[m]); end
`endif
    end
  endtask

  // req held high: 3C then C3 (dat changed right after the first accept)
  task automatic test_back_to_back();
    logic [15:0] w = '0;
    int   nrise = 0, nsnt = 0, naccept = 1, gap = 0;
    logic prev, drop_req = 1'b0, seen_low = 1'b0, gap_done = 1'b0, dat_changed = 1'b0;
    @(negedge clk);
    dat_m[0] = 8'h3C; req_m[0] = 1'b1;
    prev = sclk_m[0];
    for (int c = 1; c <= 100; c++) begin
      @(negedge clk);
      if (!dat_changed) begin dat_m[0] = 8'hC3; dat_changed = 1'b1; end
      if (drop_req) req_m[0] = 1'b0;
      if (req_m[0] && rdy_m[0]) begin naccept++; if (naccept >= 2) drop_req = 1'b1; end
      if (sclk_m[0] && !prev) begin w = {w[14:0], sdo_m[0]}; nrise++; end
      prev = sclk_m[0];
      if (snt_m[0] === 1'b1) nsnt++;
      if (cs_n_m[0] === 1'b0) begin
        if (gap > 0) gap_done = 1'b1;
        seen_low = 1'b1;
      end else if (seen_low && !gap_done) begin
        gap++;
      end
    end
    checks++; if (w !== 16'h3CC3 || nrise != 16) begin errors++; $display("FAIL b2b_sdo got %h in %0d edges want 3cc3 in 16", w, nrise); end
    checks++; if (gap != 2) begin errors++; $display("FAIL b2b_cs_gap got %0d want 2", gap); end
    checks++; if (nsnt != 2) begin errors++; $display("FAIL b2b_snt_count got %0d want 2", nsnt); end
    checks++; if (naccept != 2) begin errors++; $display("FAIL b2b_accepts got %0d want 2", naccept); end
  endtask

  // Reset when the edge counter of mode 0 reads 7 (SCLK high), mode 2 alongside
  task automatic test_mid_reset();
    int   tog = 0, nsnt = 0, nvld = 0;
    logic prev, reached = 1'b0;
    @(negedge clk);
    dat_m[0] = 8'hA5; req_m[0] = 1'b1;
    dat_m[2] = 8'hA5; req_m[2] = 1'b1;
    prev = sclk_m[0];
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      req_m[0] = 1'b0; req_m[2] = 1'b0;
      if (sclk_m[0] !== prev) tog++;
      prev = sclk_m[0];
      if (tog == 7) begin reached = 1'b1; break; end
    end
    checks++; if (!reached) begin errors++; $display("FAIL mid_reset_reach got %0d edges want 7", tog); end
    checks++; if (sclk_m[0] !== 1'b1 || sclk_m[2] !== 1'b0) begin
      errors++; $display("FAIL mid_reset_pre_sclk got %b%b want 10", sclk_m[0], sclk_m[2]);
    end
    rst = 1'b1;
    @(negedge clk);
    checks++; if (cs_n_m[0] !== 1'b1 || cs_n_m[2] !== 1'b1) begin errors++; $display("FAIL mid_reset_cs_n got %b%b want 11", cs_n_m[0], cs_n_m[2]); end
    checks++; if (sclk_m[0] !== 1'b0 || sclk_m[2] !== 1'b1) begin errors++; $display("FAIL mid_reset_sclk got %b%b want 01", sclk_m[0], sclk_m[2]); end
    checks++; if (rdy_m[0] !== 1'b1 || rdy_m[2] !== 1'b1) begin errors++; $display("FAIL mid_reset_rdy got %b%b want 11", rdy_m[0], rdy_m[2]); end
    rst = 1'b0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (snt_m[0] === 1'b1 || snt_m[2] === 1'b1) nsnt++;
      if (rx_vld_m[0] === 1'b1 || rx_vld_m[2] === 1'b1) nvld++;
    end
    checks++; if (nsnt != 0) begin errors++; $display("FAIL mid_reset_snt got %0d pulses want 0", nsnt); end
    checks++; if (nvld != 0) begin errors++; $display("FAIL mid_reset_rx_vld got %0d pulses want 0", nvld); end
    checks++; if (rx_dat_m[0] !== 8'h00) begin errors++; $display("FAIL mid_reset_rx_dat got %h want 00", rx_dat_m[0]); end
  endtask

  // DW=12, DIV=1, LSB first, 801 in loopback
  task automatic test_dw12();
    logic [11:0] w = '0;
    int   nrise = 0, snt_cyc = 0, nvld = 0, vld_cyc = 0;
    logic prev, first = 1'b0;
    @(negedge clk);
    dat12 = 12'h801; req12 = 1'b1;
    prev = sclk12;
    @(posedge clk);
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      req12 = 1'b0;
      if (sclk12 && !prev) begin
        if (nrise == 0) first = sdo12;
        w = {sdo12, w[11:1]};
        nrise++;
      end
      prev = sclk12;
      if (snt12 === 1'b1) snt_cyc = c;
      if (rx_vld12 === 1'b1) begin nvld++; vld_cyc = c; end
    end
    checks++; if (first !== 1'b1) begin errors++; $display("FAIL dw12_first_bit got %b want 1", first); end
    checks++; if (w !== 12'h801 || nrise != 12) begin errors++; $display("FAIL dw12_sdo got %h in %0d edges want 801 in 12", w, nrise); end
    checks++; if (snt_cyc != 27) begin errors++; $display("FAIL dw12_snt_cycle got %0d want 27", snt_cyc); end
    checks++; if (cs_n12 !== 1'b1 || rdy12 !== 1'b1) begin errors++; $display("FAIL dw12_idle got cs_n %b rdy %b want 1 1", cs_n12, rdy12); end
`ifdef SPI_RX_EN
    checks++; if (rx_dat12 !== 12'h801 || nvld != 1 || vld_cyc != 27) begin
      errors++; $display("FAIL dw12_rx got %h with %0d pulses at %0d want 801 1 at 27", rx_dat12, nvld, vld_cyc);
    end
`else
    checks++; if (rx_dat12 !== 12'h000 || nvld != 0) begin
      errors++; $display("FAIL dw12_rx got %h with %0d pulses want 000 0", rx_dat12, nvld);
    end
`endif
  endtask

  initial begin
    rst     = 1'b1;
    sdi_tog = 1'b0;
    req12   = 1'b0;
    dat12   = '0;
    for (int m = 0; m < 4; m++) begin
      req_m[m] = 1'b0;
      dat_m[m] = '0;
    end
    test_reset();
    test_mode0();
    test_modes();
    test_back_to_back();
    test_mid_reset();
    test_dw12();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
